wb_port_arbiter: RTL and testbench

Sequential controller for the register file's single write port. It arbitrates up to NREQ writeback requesters with round-robin priority and registers the winning write. It drives the write-address/write-enable pair that the 5-to-32 one-hot write decoder consumes. An optional busy scoreboard tracks destination registers with writes still outstanding, so the hazard logic can stall consumers.

---
 rtl/wb_pkg.sv | 13 +
 rtl/decoder_5to32.sv | 11 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/wb_port_arbiter.sv | 115 +++++++++++
 tb/tb_wb_port_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the writeback port arbiter
package wb_pkg;

  localparam int NREQ_DEFAULT = 3;
  localparam int XLEN_DEFAULT = 32;
  localparam int NREG         = 32;

  typedef logic [4:0]              reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0] word_t;

  localparam reg_addr_t REG_X0 = 5'd0;

endpackage

// File: rtl/decoder_5to32.sv
// rtl/decoder_5to32.sv - 5-to-32 one-hot write decoder with enable
module decoder_5to32 (
  input  logic [4:0]  i_in,
  input  logic        i_en,
  output logic [31:0] o_out
);

  // One bit per register, all zero when not enabled
  assign o_out = i_en ? (32'd1 << i_in) : 32'd0;

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, one-hot or zero grant
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);

  // Scan from i_ptr upward with wrap; first valid requester wins
  always_comb begin
    int  w_idx;
    logic w_found;
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - regfile write-port arbiter; optional busy scoreboard via WB_SCOREBOARD_EN
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [NREQ*5-1:0]    i_req_rd,
  input  logic [NREQ*XLEN-1:0] i_req_data,
  output logic [NREQ-1:0]      o_req_ready,
  output logic                 o_rd_wren,
  output logic [4:0]           o_rd_addr,
  output logic [XLEN-1:0]      o_rd_data,
  input  logic                 i_alloc_valid,
  input  logic [4:0]           i_alloc_rd,
  output logic [31:0]          o_busy
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   r_rr_ptr;
  logic [NREQ-1:0] w_gnt_raw;
  logic [NREQ-1:0] w_gnt;
  logic            w_gnt_any;
  logic [PW-1:0]   w_gidx;
  logic [PW-1:0]   w_ptr_nxt;
  reg_addr_t       w_rd_g;
  logic [XLEN-1:0] w_data_g;
  logic [31:0]     w_set_mask;
  logic [31:0]     w_clr_mask;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_rr_arbiter (
    .i_req (i_req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt_raw)
  );

  // No grants are issued while reset is held
  assign w_gnt       = i_reset ? '0 : w_gnt_raw;
  assign w_gnt_any   = |w_gnt;
  assign o_req_ready = w_gnt;

  // Select the winner's index, destination and data (zero when no grant)
  always_comb begin
    w_gidx   = '0;
    w_rd_g   = REG_X0;
    w_data_g = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_gidx   = PW'(i);
        w_rd_g   = i_req_rd[i*5 +: 5];
        w_data_g = i_req_data[i*XLEN +: XLEN];
      end
    end
  end

  assign w_ptr_nxt = (w_gidx == PW'(NREQ-1)) ? '0 : (w_gidx + 1'b1);

  // Round-robin pointer moves just past the winner, holds when idle
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rr_ptr <= '0;
    end else if (w_gnt_any) begin
      r_rr_ptr <= w_ptr_nxt;
    end
  end

  // Output register loads every cycle; x0 writes are consumed but not enabled
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rd_wren <= 1'b0;
      o_rd_addr <= '0;
      o_rd_data <= '0;
    end else begin
      o_rd_wren <= w_gnt_any && (w_rd_g != REG_X0);
      o_rd_addr <= w_rd_g;
      o_rd_data <= w_data_g;
    end
  end

  decoder_5to32 u_dec_set (
    .i_in  (i_alloc_rd),
    .i_en  (i_alloc_valid),
    .o_out (w_set_mask)
  );

  decoder_5to32 u_dec_clr (
    .i_in  (w_rd_g),
    .i_en  (w_gnt_any),
    .o_out (w_clr_mask)
  );

`ifdef WB_SCOREBOARD_EN
  logic [31:0] r_busy;

  // Set beats clear for the same register; x0 is never busy
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;
    end
  end

  assign o_busy = r_busy;
`else
  logic w_unused_sb;
  assign w_unused_sb = ^{w_set_mask, w_clr_mask};
  assign o_busy      = 32'd0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - table-driven bench for wb_port_arbiter
module tb_wb_port_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;

`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*5-1:0]    req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 rd_wren;
  logic [4:0]           rd_addr;
  logic [XLEN-1:0]      rd_data;
  logic                 alloc_valid;
  logic [4:0]           alloc_rd;
  logic [31:0]          busy;

  int total = 0;
  int bad   = 0;

  wb_port_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_req_valid   (req_valid),
    .i_req_rd      (req_rd),
    .i_req_data    (req_data),
    .o_req_ready   (req_ready),
    .o_rd_wren     (rd_wren),
    .o_rd_addr     (rd_addr),
    .o_rd_data     (rd_data),
    .i_alloc_valid (alloc_valid),
    .i_alloc_rd    (alloc_rd),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  rd2;
    logic [31:0] data2;
    logic [2:0]  ready;
    logic        wren;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic [2:0] v, logic [4:0] r2, logic [31:0] d2,
                              logic [2:0] rdy, logic w, logic [4:0] a, logic [31:0] d);
    vec_t t;
    t.valid = v; t.rd2 = r2; t.data2 = d2;
    t.ready = rdy; t.wren = w; t.addr = a; t.data = d;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_reqs(input logic [2:0] v, input logic [4:0] r2, input logic [31:0] d2);
    req_valid = v;
    req_rd    = {r2, 5'd7, 5'd5};
    req_data  = {d2, 32'h1111_0007, 32'hDEAD_BEEF};
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Requester 0: rd=5, req1: rd=7, req2: rd=3 unless overridden
    vecs[0]  = mk(3'b001, 5'd3, 32'h2222_0003, 3'b001, 1'b1, 5'd5, 32'hDEAD_BEEF);
    vecs[1]  = mk(3'b010, 5'd3, 32'h2222_0003, 3'b010, 1'b1, 5'd7, 32'h1111_0007);
    vecs[2]  = mk(3'b100, 5'd3, 32'h2222_0003, 3'b100, 1'b1, 5'd3, 32'h2222_0003);
    vecs[3]  = mk(3'b000, 5'd3, 32'h2222_0003, 3'b000, 1'b0, 5'd0, 32'h0);
    vecs[4]  = mk(3'b111, 5'd3, 32'h2222_0003, 3'b001, 1'b1, 5'd5, 32'hDEAD_BEEF);
    vecs[5]  = mk(3'b111, 5'd3, 32'h2222_0003, 3'b010, 1'b1, 5'd7, 32'h1111_0007);
    vecs[6]  = mk(3'b111, 5'd3, 32'h2222_0003, 3'b100, 1'b1, 5'd3, 32'h2222_0003);
    vecs[7]  = mk(3'b111, 5'd3, 32'h2222_0003, 3'b001, 1'b1, 5'd5, 32'hDEAD_BEEF);
    vecs[8]  = mk(3'b111, 5'd3, 32'h2222_0003, 3'b010, 1'b1, 5'd7, 32'h1111_0007);
    vecs[9]  = mk(3'b111, 5'd3, 32'h2222_0003, 3'b100, 1'b1, 5'd3, 32'h2222_0003);
    vecs[10] = mk(3'b101, 5'd3, 32'h2222_0003, 3'b001, 1'b1, 5'd5, 32'hDEAD_BEEF);
    vecs[11] = mk(3'b101, 5'd3, 32'h2222_0003, 3'b100, 1'b1, 5'd3, 32'h2222_0003);
    vecs[12] = mk(3'b101, 5'd3, 32'h2222_0003, 3'b001, 1'b1, 5'd5, 32'hDEAD_BEEF);
    vecs[13] = mk(3'b101, 5'd3, 32'h2222_0003, 3'b100, 1'b1, 5'd3, 32'h2222_0003);
    vecs[14] = mk(3'b100, 5'd0, 32'h0000_1234, 3'b100, 1'b0, 5'd0, 32'h0000_1234);
    vecs[15] = mk(3'b000, 5'd3, 32'h2222_0003, 3'b000, 1'b0, 5'd0, 32'h0);

    rst = 1'b1;
    alloc_valid = 1'b0;
    alloc_rd = 5'd0;
    set_reqs(3'b111, 5'd3, 32'h2222_0003);
    #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    step;
    step;
    chk("rst_wren", 64'(rd_wren), 64'h0);
    chk("rst_addr", 64'(rd_addr), 64'h0);
    chk("rst_data", 64'(rd_data), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    set_reqs(3'b000, 5'd3, 32'h2222_0003);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      set_reqs(vecs[i].valid, vecs[i].rd2, vecs[i].data2);
      #1;
      chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vecs[i].ready));
      step;
      chk($sformatf("v%0d_wren", i), 64'(rd_wren), 64'(vecs[i].wren));
      chk($sformatf("v%0d_addr", i), 64'(rd_addr), 64'(vecs[i].addr));
      chk($sformatf("v%0d_data", i), 64'(rd_data), 64'(vecs[i].data));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'h0);
    end

    // Reset in the middle of a write, with rd=4 marked busy
    alloc_valid = 1'b1;
    alloc_rd = 5'd4;
    set_reqs(3'b010, 5'd3, 32'h2222_0003);
    #1;
    chk("mid_ready", 64'(req_ready), 64'b010);
    step;
    alloc_valid = 1'b0;
    chk("mid_wren", 64'(rd_wren), 64'h1);
    chk("mid_addr", 64'(rd_addr), 64'd7);
    chk("mid_busy", 64'(busy), SB ? 64'h10 : 64'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_wren", 64'(rd_wren), 64'h0);
    chk("arst_addr", 64'(rd_addr), 64'h0);
    chk("arst_data", 64'(rd_data), 64'h0);
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_ready", 64'(req_ready), 64'h0);
    step;
    rst = 1'b0;
    set_reqs(3'b111, 5'd3, 32'h2222_0003);
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'b001);
    step;
    chk("post_rst_addr", 64'(rd_addr), 64'd5);

    // Scoreboard sequence (pointer now 1)
    set_reqs(3'b000, 5'd3, 32'h2222_0003);
    alloc_valid = 1'b1;
    alloc_rd = 5'd7;
    step;
    chk("sb_alloc7_busy", 64'(busy), SB ? 64'h80 : 64'h0);
    chk("sb_alloc7_wren", 64'(rd_wren), 64'h0);
    alloc_rd = 5'd0;
    set_reqs(3'b010, 5'd3, 32'h2222_0003);
    #1;
    chk("sb_clr_ready", 64'(req_ready), 64'b010);
    step;
    chk("sb_clr_wren", 64'(rd_wren), 64'h1);
    chk("sb_clr_addr", 64'(rd_addr), 64'd7);
    chk("sb_clr_busy", 64'(busy), 64'h0);
    alloc_rd = 5'd7;
    set_reqs(3'b000, 5'd3, 32'h2222_0003);
    step;
    chk("sb_realloc_busy", 64'(busy), SB ? 64'h80 : 64'h0);
    set_reqs(3'b010, 5'd3, 32'h2222_0003);
    #1;
    chk("sb_same_ready", 64'(req_ready), 64'b010);
    step;
    chk("sb_same_wren", 64'(rd_wren), 64'h1);
    chk("sb_same_busy", 64'(busy), SB ? 64'h80 : 64'h0);
    alloc_rd = 5'd9;
    set_reqs(3'b001, 5'd3, 32'h2222_0003);
    #1;
    chk("sb_a9_ready", 64'(req_ready), 64'b001);
    step;
    alloc_valid = 1'b0;
    set_reqs(3'b000, 5'd3, 32'h2222_0003);
    chk("sb_a9_addr", 64'(rd_addr), 64'd5);
    chk("sb_a9_busy", 64'(busy), SB ? 64'h280 : 64'h0);
    step;
    chk("sb_idle_wren", 64'(rd_wren), 64'h0);
    chk("sb_idle_busy", 64'(busy), SB ? 64'h280 : 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
